// File: rtl/bayer_pattern_gen_pkg.sv
// bayer_pattern_gen_pkg: shared FSM states, pattern codes and colour constants
package bayer_pattern_gen_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, H_BLANK, V_BLANK} state_e;
   typedef enum logic [1:0] {PAT_FLAT, PAT_RAMP, PAT_CHECK, PAT_BAYER} pattern_e;
   localparam logic [11:0] COL_G    = 12'h400;
   localparam logic [11:0] COL_R    = 12'hC00;
   localparam logic [11:0] COL_B    = 12'h200;
   localparam logic [11:0] COL_FLAT = 12'h800;
endpackage

// File: rtl/bayer_pattern_gen_if.sv
// bayer_pattern_gen_if: pixel stream as seen by the grayscale converter
interface bayer_pattern_gen_if;
   logic [11:0] oDATA;
   logic        oDVAL;
   logic [15:0] oX_Cont;
   logic [15:0] oY_Cont;
   logic        oFVAL;
   modport master (output oDATA, oDVAL, oX_Cont, oY_Cont, oFVAL);
   modport slave  (input  oDATA, oDVAL, oX_Cont, oY_Cont, oFVAL);
endinterface

// File: rtl/bayer_pattern_lut.sv
// bayer_pattern_lut: combinational (pattern, X, Y) to 12-bit pixel value
module bayer_pattern_lut
   import bayer_pattern_gen_pkg::*;
(
   input  pattern_e    pattern,
   input  logic [11:0] x,
   input  logic [1:0]  y,
   output logic [11:0] data
);
   // checker uses bit 1 so each 2x2 block covers exactly one Bayer quad
   assign data = pattern == PAT_FLAT  ? COL_FLAT :
                 pattern == PAT_RAMP  ? x :
                 pattern == PAT_CHECK ? {12{x[1] ^ y[1]}} :
                 (x[0] ^ y[0])        ? (x[0] ? COL_R : COL_B) : COL_G;
endmodule

// File: rtl/bayer_pattern_gen.sv
// bayer_pattern_gen: synthetic Bayer pixel source with programmable blanking
module bayer_pattern_gen
   import bayer_pattern_gen_pkg::*;
#(
   parameter int BAYER_COLS = 1280,
   parameter int BAYER_ROWS = 960,
   parameter int HBLANK     = 16,
   parameter int VBLANK     = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 iStart,
   input  logic                 iStop,
   input  logic                 iHold,
   input  logic [1:0]           iPattern,
   output logic [15:0]          oFrame_Cont,
   output logic                 oBusy,
   bayer_pattern_gen_if.master  px
);
   localparam logic [15:0] X_LAST = 16'(BAYER_COLS - 1);
   localparam logic [15:0] Y_LAST = 16'(BAYER_ROWS - 1);
   localparam logic [15:0] H_LAST = 16'(HBLANK - 1);
   localparam logic [15:0] V_LAST = 16'(VBLANK - 1);
   state_e      state, state_n;
   pattern_e    pat, pat_n;
   logic [15:0] x, x_n, y, y_n, bcnt, bcnt_n, frames, frames_n;
   logic [11:0] data, data_n, lut_data;
   logic        dval, dval_n, fval, fval_n, stop, stop_n;
   bayer_pattern_lut u_lut (
      .pattern (pat_n),
      .x       (x_n[11:0]),
      .y       (y_n[1:0]),
      .data    (lut_data)
   );
   always_comb begin
      state_n  = state;
      pat_n    = pat;
      x_n      = x;
      y_n      = y;
      bcnt_n   = bcnt;
      frames_n = frames;
      dval_n   = 1'b0;
      fval_n   = fval;
      stop_n   = stop | (iStop && state != IDLE);
      case (state)
         IDLE: if (iStart) begin
            state_n = ACTIVE;
            pat_n   = pattern_e'(iPattern);
            x_n     = '0;
            y_n     = '0;
            dval_n  = 1'b1;
            fval_n  = 1'b1;
         end
         ACTIVE: if (!iHold) begin
            if (x == X_LAST) begin
               x_n    = '0;
               bcnt_n = '0;
               state_n = y == Y_LAST ? V_BLANK : H_BLANK;
               if (y == Y_LAST) begin
                  y_n      = '0;
                  fval_n   = 1'b0;
                  frames_n = frames + 16'd1;
               end
            end else begin
               x_n    = x + 16'd1;
               dval_n = 1'b1;
            end
         end
         H_BLANK: if (bcnt == H_LAST) begin
            state_n = ACTIVE;
            y_n     = y + 16'd1;
            dval_n  = 1'b1;
         end else bcnt_n = bcnt + 16'd1;
         V_BLANK: if (bcnt != V_LAST) bcnt_n = bcnt + 16'd1;
         else if (stop_n) begin
            state_n = IDLE;
            stop_n  = 1'b0;
         end else begin
            state_n = ACTIVE;
            pat_n   = pattern_e'(iPattern);
            dval_n  = 1'b1;
            fval_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      data_n = dval_n ? lut_data : data;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pat    <= PAT_FLAT;
         x      <= '0;
         y      <= '0;
         bcnt   <= '0;
         frames <= '0;
         data   <= '0;
         dval   <= 1'b0;
         fval   <= 1'b0;
         stop   <= 1'b0;
      end else begin
         state  <= state_n;
         pat    <= pat_n;
         x      <= x_n;
         y      <= y_n;
         bcnt   <= bcnt_n;
         frames <= frames_n;
         data   <= data_n;
         dval   <= dval_n;
         fval   <= fval_n;
         stop   <= stop_n;
      end
   end
   assign px.oDATA    = data;
   assign px.oDVAL    = dval;
   assign px.oX_Cont  = x;
   assign px.oY_Cont  = y;
   assign px.oFVAL    = fval;
   assign oFrame_Cont = frames;
   assign oBusy       = state != IDLE;
endmodule

// File: tb/tb_bayer_pattern_gen.sv
// tb_bayer_pattern_gen: directed scenarios plus random traffic against a pixel-index model
module tb_bayer_pattern_gen;
   localparam int C = 8, R = 4, H = 2, V = 3;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        start = 1'b0, stop = 1'b0, hold = 1'b0;
   logic [1:0]  pattern = 2'd0;
   logic [15:0] frame_cont;
   logic        busy;
   int          tests = 0, fails = 0;
   bayer_pattern_gen_if px ();
   bayer_pattern_gen #(.BAYER_COLS(C), .BAYER_ROWS(R), .HBLANK(H), .VBLANK(V)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .iStart      (start),
      .iStop       (stop),
      .iHold       (hold),
      .iPattern    (pattern),
      .oFrame_Cont (frame_cont),
      .oBusy       (busy),
      .px          (px)
   );
   always #5 clk = ~clk;
   // model: pos = pixels emitted so far in the frame, blank = blanking cycles left
   bit running, in_v, stop_f, e_dval, e_fval;
   int pos, blank, m_pat, e_x, e_y, frames;
   logic [11:0] e_data;
   function automatic logic [11:0] pix(int p, int x, int y);
      case (p)
         0: return 12'h800;
         1: return 12'(x % 4096);
         2: return (((x / 2) + (y / 2)) % 2) != 0 ? 12'hFFF : 12'h000;
         default: return (y % 2 == 0) ? ((x % 2 != 0) ? 12'hC00 : 12'h400)
                                      : ((x % 2 != 0) ? 12'h400 : 12'h200);
      endcase
   endfunction
   task automatic emit();
      e_dval = 1'b1;
      e_x    = (pos - 1) % C;
      e_y    = (pos - 1) / C;
      e_data = pix(m_pat, e_x, e_y);
   endtask
   task automatic new_frame(int p);
      m_pat  = p;
      pos    = 1;
      in_v   = 1'b0;
      blank  = 0;
      e_fval = 1'b1;
      emit();
   endtask
   task automatic m_step();
      e_dval = 1'b0;
      if (running) stop_f |= stop;
      if (!running) begin
         if (start) begin
            running = 1'b1;
            new_frame(int'(pattern));
         end
      end else if (blank > 0) begin
         blank--;
         if (blank == 0) begin
            if (!in_v) begin
               pos++;
               emit();
            end else if (stop_f) begin
               running = 1'b0;
               stop_f  = 1'b0;
            end else new_frame(int'(pattern));
         end
      end else if (hold) begin
         e_dval = 1'b0;
      end else if (pos % C == 0) begin
         e_x = 0;
         if (pos == C * R) begin
            in_v   = 1'b1;
            blank  = V;
            e_y    = 0;
            e_fval = 1'b0;
            frames = (frames + 1) % 65536;
         end else blank = H;
      end else begin
         pos++;
         emit();
      end
   endtask
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running = 1'b0; in_v = 1'b0; stop_f = 1'b0; e_dval = 1'b0; e_fval = 1'b0;
         pos = 0; blank = 0; m_pat = 0; e_x = 0; e_y = 0; frames = 0; e_data = '0;
      end else m_step();
   end
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("model dval", 32'(px.oDVAL), 32'(e_dval));
         chk("model fval", 32'(px.oFVAL), 32'(e_fval));
         chk("model busy", 32'(busy), 32'(running));
         chk("model x", 32'(px.oX_Cont), 32'(e_x));
         chk("model y", 32'(px.oY_Cont), 32'(e_y));
         chk("model frames", 32'(frame_cont), 32'(frames));
         if (e_dval) chk("model data", 32'(px.oDATA), 32'(e_data));
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_for(int wx, int wy, string nm, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!(px.oDVAL && px.oX_Cont == 16'(wx) && px.oY_Cont == 16'(wy)) && n < 400);
      chk({nm, " reached"}, 32'(n < 400), 32'd1);
   endtask
   task automatic reset_dut();
      start = 1'b0; stop = 1'b0; hold = 1'b0;
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask
   task automatic kick(logic [1:0] p);
      pattern = p;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask
   task automatic chk_zero(string nm);
      chk({nm, " dval"}, 32'(px.oDVAL), 0);
      chk({nm, " fval"}, 32'(px.oFVAL), 0);
      chk({nm, " x"}, 32'(px.oX_Cont), 0);
      chk({nm, " y"}, 32'(px.oY_Cont), 0);
      chk({nm, " data"}, 32'(px.oDATA), 0);
      chk({nm, " frames"}, 32'(frame_cont), 0);
      chk({nm, " busy"}, 32'(busy), 0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end
   initial begin
      int n, n1, n2;
      #3;
      chk_zero("reset");
      reset_dut();
      // flat pattern and frame period
      kick(2'd0);
      chk("flat first dval", 32'(px.oDVAL), 1);
      chk("flat first data", 32'(px.oDATA), 32'h800);
      wait_for(0, 0, "flat next frame", n);
      chk("flat period", n, 41);
      chk("flat frames", 32'(frame_cont), 1);
      // checker
      reset_dut();
      kick(2'd2);
      wait_for(2, 0, "chk (2,0)", n);
      chk("checker (2,0)", 32'(px.oDATA), 32'hFFF);
      wait_for(0, 2, "chk (0,2)", n);
      chk("checker (0,2)", 32'(px.oDATA), 32'hFFF);
      wait_for(2, 2, "chk (2,2)", n);
      chk("checker (2,2)", 32'(px.oDATA), 32'h000);
      // ramp with hold
      reset_dut();
      kick(2'd1);
      wait_for(5, 1, "ramp (5,1)", n1);
      hold = 1'b1;
      repeat (3) begin
         step();
         chk("hold dval", 32'(px.oDVAL), 0);
         chk("hold x", 32'(px.oX_Cont), 5);
      end
      hold = 1'b0;
      step();
      chk("ramp x6", 32'(px.oX_Cont), 6);
      chk("ramp d6", 32'(px.oDATA), 6);
      step();
      chk("ramp x7", 32'(px.oX_Cont), 7);
      chk("ramp d7", 32'(px.oDATA), 7);
      wait_for(0, 0, "ramp next frame", n2);
      chk("hold period", n1 + 5 + n2, 44);
      // stop at frame end
      reset_dut();
      kick(2'd0);
      repeat (10) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         step();
         n++;
      end
      chk("stop idle after", n, 30);
      chk("stop frames", 32'(frame_cont), 1);
      repeat (20) begin
         step();
         chk("stop no dval", 32'(px.oDVAL), 0);
      end
      // pattern latch
      reset_dut();
      kick(2'd0);
      repeat (5) step();
      pattern = 2'd3;
      step();
      chk("latch mid frame", 32'(px.oDATA), 32'h800);
      wait_for(0, 0, "latch frame2", n);
      chk("latch (0,0)", 32'(px.oDATA), 32'h400);
      step();
      chk("latch (1,0)", 32'(px.oDATA), 32'hC00);
      wait_for(0, 1, "latch (0,1)", n);
      chk("latch (0,1)", 32'(px.oDATA), 32'h200);
      // async reset mid-row
      reset_dut();
      kick(2'd1);
      wait_for(3, 0, "areset row", n);
      #2 rst_n = 1'b0;
      #1 chk_zero("async reset");
      start = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      chk("restart dval", 32'(px.oDVAL), 1);
      chk("restart x", 32'(px.oX_Cont), 0);
      chk("restart y", 32'(px.oY_Cont), 0);
      start = 1'b0;
      // random traffic against the model
      reset_dut();
      for (int i = 0; i < 4000; i++) begin
         start   = ($urandom % 10) == 0;
         stop    = ($urandom % 50) == 0;
         hold    = ($urandom % 5) == 0;
         pattern = 2'($urandom % 4);
         step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
